// File: rtl/frac_div_seq.sv
// frac_div_seq: sequential restoring divider for unsigned Q0.N fractions.
// Computes o = floor(X * 2^N / D) one quotient bit per clock, MSB first.
// D == 0 or X >= D saturates to all-ones with ovf set. Valid/ready on both sides.
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// CALC  | N restoring iterations, inputs ignored
// DONE  | result presented on o/r/ovf with out_valid high
module frac_div_seq #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] g_input,
    input  logic [N-1:0] e_input,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] o,
    output logic [N-1:0] r,
    output logic         ovf
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [N:0]    rem;
    logic [N-1:0]  qacc;
    logic [N-1:0]  dvs;
    logic [CW-1:0] cnt;

    logic [N:0]    rem_sh;
    logic [N:0]    rem_nxt;
    logic [N-1:0]  qacc_nxt;
    logic          q_bit;
    logic          last;
    logic          sat;

    // One restoring step; rem < dvs is kept, so the shifted-out MSB is always zero.
    always_comb begin
        rem_sh   = rem << 1;
        q_bit    = (rem_sh >= {1'b0, dvs});
        rem_nxt  = q_bit ? (rem_sh - {1'b0, dvs}) : rem_sh;
        qacc_nxt = {qacc[N-2:0], q_bit};
        last     = (cnt == CW'(N - 1));
        sat      = (e_input == '0) || (g_input >= e_input);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = sat ? DONE : CALC;
            CALC:    if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand latch, iteration registers and held result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem  <= '0;
            qacc <= '0;
            dvs  <= '0;
            cnt  <= '0;
            o    <= '0;
            r    <= '0;
            ovf  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvs  <= e_input;
                        qacc <= '0;
                        cnt  <= '0;
                        if (sat) begin
                            rem <= '0;
                            o   <= '1;
                            r   <= '0;
                            ovf <= 1'b1;
                        end else begin
                            rem <= {1'b0, g_input};
                            ovf <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    rem  <= rem_nxt;
                    qacc <= qacc_nxt;
                    cnt  <= cnt + CW'(1);
                    if (last) begin
                        o <= qacc_nxt;
                        r <= rem_nxt[N-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Handshake outputs are pure decodes of the registered state.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

endmodule

// File: tb/tb_frac_div_seq.sv
// Directed and randomised checks for frac_div_seq (N = 8).
module tb_frac_div_seq;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [N-1:0] g_input = '0;
    logic [N-1:0] e_input = '0;
    logic         in_ready;
    logic         out_valid;
    logic [N-1:0] o;
    logic [N-1:0] r;
    logic         ovf;

    int total = 0;
    int bad   = 0;

    frac_div_seq #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .g_input   (g_input),
        .e_input   (e_input),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .o         (o),
        .r         (r),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present operands at a negedge once in_ready is seen; returns #1 after the accept edge.
    task automatic start(input logic [N-1:0] x, input logic [N-1:0] d, input bit hold);
        int w;
        w = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("start_in_ready", {31'd0, in_ready}, 32'd1);
        g_input  = x;
        e_input  = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    // Count edges after the accept edge until out_valid; optionally scramble inputs while busy.
    task automatic wait_done(input bit scramble, output int k);
        k = 0;
        while (out_valid !== 1'b1 && k < 40) begin
            if (scramble) begin
                chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
                g_input = N'($urandom);
                e_input = N'($urandom);
            end
            @(posedge clk);
            #1;
            k++;
        end
        if (scramble) chk("done_in_ready_hold", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
    endtask

    task automatic take(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_ret_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_ret_in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic op(input string tag, input logic [N-1:0] x, input logic [N-1:0] d,
                      input logic [N-1:0] eo, input logic [N-1:0] er, input logic eovf,
                      input int elat);
        int k;
        start(x, d, 1'b0);
        wait_done(1'b0, k);
        chk({tag, "_lat"}, k, elat);
        chk({tag, "_o"}, {24'd0, o}, {24'd0, eo});
        chk({tag, "_r"}, {24'd0, r}, {24'd0, er});
        chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eovf});
        chk({tag, "_done_in_ready"}, {31'd0, in_ready}, 32'd0);
        take(tag);
    endtask

    initial begin
        logic [N-1:0] x;
        logic [N-1:0] d;
        int k;

        // Reset state
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_o", {24'd0, o}, 32'd0);
        chk("rst_r", {24'd0, r}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        #10 rst = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed vectors
        op("half", 8'h40, 8'h80, 8'h80, 8'h00, 1'b0, N);
        op("third", 8'h01, 8'h03, 8'h55, 8'h01, 1'b0, N);
        chk("third_identity", 32'h55 * 32'd3 + 32'd1, 32'h100);
        op("eq_sat", 8'h80, 8'h80, 8'hFF, 8'h00, 1'b1, 0);
        op("zero_div", 8'h10, 8'h00, 8'hFF, 8'h00, 1'b1, 0);
        op("zero_num", 8'h00, 8'h05, 8'h00, 8'h00, 1'b0, N);
        op("quot_of_30_90", 8'h30, 8'h90, 8'h55, 8'h30, 1'b0, N);

        // Result held while consumer stalls
        start(8'h7F, 8'hFF, 1'b0);
        wait_done(1'b0, k);
        chk("stall_lat", k, N);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_o", {24'd0, o}, 32'h7F);
            chk("stall_r", {24'd0, r}, 32'h7F);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        take("stall");

        // Asynchronous reset in the middle of CALC
        start(8'h30, 8'h90, 1'b0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_o", {24'd0, o}, 32'd0);
        chk("midrst_r", {24'd0, r}, 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_out_valid2", {31'd0, out_valid}, 32'd0);
        op("after_rst", 8'h01, 8'h02, 8'h80, 8'h00, 1'b0, N);

        // Random sweep with handshake gaps and inputs scrambled while busy
        for (int i = 0; i < 1000; i++) begin
            d = N'($urandom_range(1, 255));
            x = N'($urandom_range(0, int'(d) - 1));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            start(x, d, 1'b1);
            wait_done(1'b1, k);
            chk("rnd_lat", k, N);
            chk("rnd_ovf", {31'd0, ovf}, 32'd0);
            chk("rnd_identity", 32'(o) * 32'(d) + 32'(r), 32'(x) * 32'd256);
            chk("rnd_r_lt_d", {31'd0, (r < d)}, 32'd1);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            chk("rnd_hold_valid", {31'd0, out_valid}, 32'd1);
            take("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
